enc83_drain: RTL and testbench

ENC83_DRAIN -- requirements
Module: enc83_drain

---
 rtl/enc83_pkg.sv | 26 ++
 rtl/enc83_drain_if.sv | 27 ++
 rtl/enc83_pick.sv | 31 +++
 rtl/enc83_drain.sv | 103 ++++++++++
 tb/tb_enc83_drain.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc83_pkg.sv
// Shared types and constants for the 8:3 draining encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum (IDLE, DRAIN), vector width N, index width AW,
// and a bit-reverse helper used to express highest-index priority as a
// lowest-index search.
package enc83_pkg;

    localparam int N  = 8;
    localparam int AW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/enc83_drain_if.sv
// Request/response bus between a producer of multi-hot vectors and the encoder.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, out_valid/out_ready on the output side.
// Signals: e (enable), req_valid, req_ready, req_d[7:0], out_valid, out_ready,
// out_a[2:0], out_last.  master = vector producer / index consumer, slave = encoder.
interface enc83_drain_if;
    import enc83_pkg::*;

    logic          e;
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_d;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_a;
    logic          out_last;

    modport master (
        output e, req_valid, req_d, out_ready,
        input  req_ready, out_valid, out_a, out_last
    );

    modport slave (
        input  e, req_valid, req_d, out_ready,
        output req_ready, out_valid, out_a, out_last
    );
endinterface

// File: rtl/enc83_pick.sv
// Combinational picker: lowest set index of vec at or after start, wrapping modulo N.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: vec[7:0] candidate bits, start[2:0] search origin, idx[2:0] chosen index,
// found = vec has any bit set (idx is 0 when not found).
module enc83_pick
    import enc83_pkg::*;
(
    input  logic [N-1:0]  vec,
    input  logic [AW-1:0] start,
    output logic [AW-1:0] idx,
    output logic          found
);

    logic [AW-1:0] pos;

    // Scan from farthest to nearest so the position closest to start wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = start + AW'(k);
            if (vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc83_drain.sv
// Accepts a multi-hot 8-bit vector and drains it one encoded index per accepted output.
// Latency: first out_valid one cycle after acceptance; one index per out_ready cycle.
// Backpressure: req_ready only in IDLE; out_ready=0 holds out_a/out_last/pending.
// Ports: clk, rst_n (async active-low), bus (enc83_drain_if.slave),
// overrun_cnt[ERR_W-1:0] = saturating count of cycles with req_valid & !req_ready.
// Build option: ENC83_RR_EN selects round-robin instead of highest-index priority.
module enc83_drain
    import enc83_pkg::*;
#(
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    enc83_drain_if.slave     bus,
    output logic [ERR_W-1:0] overrun_cnt
);

    state_t        state;
    logic [N-1:0]  pending;
    logic          live;       // low through reset, high from first edge after release
    logic          accept_ok;
    logic          out_vld;
    logic          last_bit;
    logic [AW-1:0] sel;
    logic [AW-1:0] pick_idx;
    logic          pick_found;

`ifdef ENC83_RR_EN
    logic [AW-1:0] ptr;

    enc83_pick u_pick (
        .vec   (pending),
        .start (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign sel = pick_idx;
`else
    // Highest set index == lowest set index of the bit-reversed vector.
    enc83_pick u_pick (
        .vec   (bitrev(pending)),
        .start ('0),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign sel = AW'(N - 1) - pick_idx;
`endif

    assign accept_ok = live && (state == IDLE);
    assign out_vld   = (state == DRAIN);
    assign last_bit  = pick_found && ((pending & (pending - 1'b1)) == '0);

    assign bus.req_ready = accept_ok;
    assign bus.out_valid = out_vld;
    assign bus.out_a     = out_vld ? sel : '0;
    assign bus.out_last  = out_vld && last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            live        <= 1'b0;
            overrun_cnt <= '0;
`ifdef ENC83_RR_EN
            ptr         <= '0;
`endif
        end else begin
            live <= 1'b1;

            if (bus.req_valid && !accept_ok && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    // Disabled or empty vectors complete the handshake but load nothing.
                    if (bus.req_valid && accept_ok && bus.e && (bus.req_d != '0)) begin
                        pending <= bus.req_d;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        pending <= pending & ~(N'(1) << sel);
`ifdef ENC83_RR_EN
                        ptr     <= sel + AW'(1);
`endif
                        if (last_bit) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc83_drain.sv
// Self-checking bench for enc83_drain: directed vectors feed a scoreboard queue,
// an independent monitor pops and compares on every accepted output.
module tb_enc83_drain;
    import enc83_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] overrun_cnt;

    enc83_drain_if bus();

    enc83_drain #(.ERR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mptr   = 0;
    logic [3:0] sb[$];   // {last, a}

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input int last);
        logic [3:0] ent;
        ent = {last[0], a[2:0]};
        sb.push_back(ent);
    endtask

    // Reference model of the selection order for a whole vector.
    task automatic push_model(input logic [7:0] v);
`ifdef ENC83_RR_EN
        logic [7:0] p;
        int g;
        p = v;
        while (p != 8'h00) begin
            g = -1;
            for (int k = 0; k < 8; k++) begin
                if (g < 0 && p[(mptr + k) % 8]) g = (mptr + k) % 8;
            end
            p[g] = 1'b0;
            push(g, (p == 8'h00) ? 1 : 0);
            mptr = (g + 1) % 8;
        end
`else
        logic [7:0] below;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                below = v & ((8'h01 << i) - 8'h01);
                push(i, (below == 8'h00) ? 1 : 0);
            end
        end
`endif
    endtask

    // Monitor: compares every accepted output against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out: got out_a=%0d with no expected entry at %0t",
                             bus.out_a, $time);
                end else begin
                    logic [3:0] ent;
                    ent = sb.pop_front();
                    chk("out_a", int'(bus.out_a), int'(ent[2:0]));
                    chk("out_last", int'(bus.out_last), int'(ent[3]));
                end
            end
            if (!bus.out_valid) begin
                chk("idle_out_a_zero", int'(bus.out_a), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.req_ready && t < 100) begin
            tick(1);
            t++;
        end
        if (!bus.req_ready) chk("wait_ready_timeout", int'(bus.req_ready), 1);
    endtask

    task automatic send(input logic [7:0] v, input logic en);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_d     = v;
        bus.e         = en;
        tick(1);
        bus.req_valid = 1'b0;
        bus.e         = 1'b0;
        bus.req_d     = 8'h00;
    endtask

    task automatic drain_wait(input string name);
        int t;
        t = 0;
        while ((!bus.req_ready || sb.size() != 0) && t < 200) begin
            tick(1);
            t++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.e         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_d     = 8'h00;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        #2;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_a", int'(bus.out_a), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_first_edge", int'(bus.req_ready), 0);
        tick(1);
        chk("rdy_after_first_edge", int'(bus.req_ready), 1);

        // Basic drain of 1010_0100
`ifdef ENC83_RR_EN
        push(2, 0); push(5, 0); push(7, 1);
`else
        push(7, 0); push(5, 0); push(2, 1);
`endif
        send(8'hA4, 1'b1);
        chk("a4_rdy_in_drain", int'(bus.req_ready), 0);
        chk("a4_out_valid", int'(bus.out_valid), 1);
        tick(2);
        chk("a4_rdy_before_last", int'(bus.req_ready), 0);
        tick(1);
        chk("a4_rdy_after_last", int'(bus.req_ready), 1);
        chk("a4_out_valid_done", int'(bus.out_valid), 0);
        chk("a4_sb_empty", sb.size(), 0);

        // Disabled vector is discarded
        send(8'hFF, 1'b0);
        chk("dis_out_valid", int'(bus.out_valid), 0);
        chk("dis_req_ready", int'(bus.req_ready), 1);
        tick(3);
        chk("dis_out_valid_later", int'(bus.out_valid), 0);
        chk("dis_req_ready_later", int'(bus.req_ready), 1);

        // Stall with overrun counting and saturation
        bus.out_ready = 1'b0;
`ifdef ENC83_RR_EN
        push(2, 0); push(5, 0); push(7, 1);
`else
        push(7, 0); push(5, 0); push(2, 1);
`endif
        send(8'hA4, 1'b1);
        chk("ovr_start", int'(overrun_cnt), 0);
        bus.req_valid = 1'b1;
        bus.e         = 1'b1;
        bus.req_d     = 8'h55;
        tick(5);
        chk("ovr_5", int'(overrun_cnt), 5);
`ifdef ENC83_RR_EN
        chk("stall_out_a_hold", int'(bus.out_a), 2);
`else
        chk("stall_out_a_hold", int'(bus.out_a), 7);
`endif
        chk("stall_out_last_hold", int'(bus.out_last), 0);
        chk("stall_out_valid", int'(bus.out_valid), 1);
        tick(15);
        chk("ovr_sat_15", int'(overrun_cnt), 15);
        bus.req_valid = 1'b0;
        bus.e         = 1'b0;
        bus.req_d     = 8'h00;
        bus.out_ready = 1'b1;
        drain_wait("stall_drain");
        chk("ovr_sat_hold", int'(overrun_cnt), 15);

        // Reset mid-DRAIN after the first output of 8'hFF
`ifdef ENC83_RR_EN
        push(0, 0);
`else
        push(7, 0);
`endif
        send(8'hFF, 1'b1);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_out_a", int'(bus.out_a), 0);
        chk("mid_rst_out_last", int'(bus.out_last), 0);
        chk("mid_rst_req_ready", int'(bus.req_ready), 0);
        chk("mid_rst_overrun", int'(overrun_cnt), 0);
        chk("mid_rst_first_seen", sb.size(), 0);
        sb.delete();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_req_ready", int'(bus.req_ready), 1);
        push(0, 1);
        send(8'h01, 1'b1);
        drain_wait("post_rst_drain");

`ifdef ENC83_RR_EN
        // Round-robin ordering from a fresh pointer
        pulse_reset();
        push(0, 0); push(7, 1);
        send(8'h81, 1'b1);
        drain_wait("rr_81_first");
        push(0, 0); push(7, 1);
        send(8'h81, 1'b1);
        drain_wait("rr_81_second");
        push(1, 1);
        send(8'h02, 1'b1);
        push(2, 0); push(1, 1);
        send(8'h06, 1'b1);
        drain_wait("rr_06");
        mptr = 2;
`endif

        // Sweep every vector value
        for (int v = 0; v < 256; v++) begin
            push_model(v[7:0]);
            send(v[7:0], 1'b1);
        end
        drain_wait("sweep_drain");
        tick(3);
        chk("final_out_valid", int'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
